// File: rtl/irq_ctrl_pkg.sv
// Shared types and helpers for the irq_ctrl interrupt controller.
// Optional build macro: IRQ_CTRL_EDGE_DETECT_EN (level inputs, rising-edge capture).
package irq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_e;

    localparam int N_SRC_DEF = 4;
    localparam int MAX_SRC   = 16;
    localparam int IDX_W     = 4;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [MAX_SRC-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = MAX_SRC - 1; i >= 0; i--) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// Peripheral/CPU-facing signal bundle of irq_ctrl; master drives requests and
// handshakes, slave is the controller.
interface irq_ctrl_if
    import irq_ctrl_pkg::*;
#(
    parameter int N_SRC = N_SRC_DEF
);
    localparam int VEC_W = $clog2(N_SRC);

    logic [N_SRC-1:0] IRQ_IN;
    logic [N_SRC-1:0] IE_WDATA;
    logic             IE_WE;
    logic             INTA;
    logic             RETI;
    logic             IRQ;
    logic [VEC_W-1:0] VECTOR;
    logic [N_SRC-1:0] PENDING;
    logic             BUSY;

    modport master (
        output IRQ_IN, IE_WDATA, IE_WE, INTA, RETI,
        input  IRQ, VECTOR, PENDING, BUSY
    );

    modport slave (
        input  IRQ_IN, IE_WDATA, IE_WE, INTA, RETI,
        output IRQ, VECTOR, PENDING, BUSY
    );

endinterface

// File: rtl/irq_prio_enc.sv
// Combinational fixed-priority encoder: lowest set index of active wins.
module irq_prio_enc
    import irq_ctrl_pkg::*;
#(
    parameter int N_SRC = N_SRC_DEF,
    parameter int VEC_W = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] active,
    output logic [VEC_W-1:0] idx,
    output logic             any
);

    always_comb begin
        any = |active;
        idx = VEC_W'(lowest_set(MAX_SRC'(active)));
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: pending capture, enable masking, fixed-priority arbitration
// and INTA/RETI handshake. Build macro IRQ_CTRL_EDGE_DETECT_EN enables edge capture.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int N_SRC = N_SRC_DEF
) (
    input  logic      CLK,
    input  logic      RST_N,
    irq_ctrl_if.slave bus
);

    localparam int VEC_W = $clog2(N_SRC);

    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] ie_q, ie_d;
    irq_state_e       state_q, state_d;
    logic             irq_q, irq_d;
    logic             busy_q, busy_d;
    logic [VEC_W-1:0] vector_q, vector_d;

    logic [N_SRC-1:0] irq_evt;
    logic [N_SRC-1:0] active;
    logic [VEC_W-1:0] win_idx;
    logic             win_any;

`ifdef IRQ_CTRL_EDGE_DETECT_EN
    logic [N_SRC-1:0] irq_prev_q, irq_prev_d;

    assign irq_prev_d = bus.IRQ_IN;
    assign irq_evt    = bus.IRQ_IN & ~irq_prev_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) irq_prev_q <= '0;
        else        irq_prev_q <= irq_prev_d;
    end
`else
    assign irq_evt = bus.IRQ_IN;
`endif

    assign active = pending_q & ie_q;

    irq_prio_enc #(
        .N_SRC (N_SRC),
        .VEC_W (VEC_W)
    ) u_prio_enc (
        .active (active),
        .idx    (win_idx),
        .any    (win_any)
    );

    always_comb begin
        // NOTE: every _d takes its hold value first, so no branch can leave one unassigned and infer a latch.
        pending_d = pending_q;
        ie_d      = bus.IE_WE ? bus.IE_WDATA : ie_q;
        state_d   = state_q;
        irq_d     = irq_q;
        busy_d    = busy_q;
        vector_d  = vector_q;

        case (state_q)
            ST_IDLE: begin
                if (win_any) begin
                    state_d  = ST_REQ;
                    irq_d    = 1'b1;
                    vector_d = win_idx;
                end
            end
            ST_REQ: begin
                if (bus.INTA) begin
                    pending_d[vector_q] = 1'b0;
                    state_d             = ST_SERVICE;
                    irq_d               = 1'b0;
                    busy_d              = 1'b1;
                end else if (!(ie_q[vector_q] && pending_q[vector_q])) begin
                    state_d = ST_IDLE;
                    irq_d   = 1'b0;
                end
            end
            ST_SERVICE: begin
                if (bus.RETI) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                irq_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        // A new event in the acknowledge cycle must survive the clear.
        pending_d = pending_d | irq_evt;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pending_q <= '0;
            ie_q      <= '0;
            state_q   <= ST_IDLE;
            irq_q     <= 1'b0;
            busy_q    <= 1'b0;
            vector_q  <= '0;
        end else begin
            pending_q <= pending_d;
            ie_q      <= ie_d;
            state_q   <= state_d;
            irq_q     <= irq_d;
            busy_q    <= busy_d;
            vector_q  <= vector_d;
        end
    end

    assign bus.IRQ     = irq_q;
    assign bus.VECTOR  = vector_q;
    assign bus.PENDING = pending_q;
    assign bus.BUSY    = busy_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios plus randomized traffic
// against a mode-based reference model. Honours IRQ_CTRL_EDGE_DETECT_EN.
module tb_irq_ctrl;

    localparam int N = 4;

    logic CLK;
    logic RST_N;

    irq_ctrl_if #(.N_SRC(N)) bus ();

    irq_ctrl #(.N_SRC(N)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0 = waiting, 1 = requesting, 2 = in handler.
    int         m_mode;
    logic [1:0] m_vec;
    logic [3:0] m_pending;
    logic [3:0] m_ie;
    logic [3:0] m_prev;

    task automatic model_reset();
        m_mode    = 0;
        m_vec     = 2'd0;
        m_pending = 4'b0;
        m_ie      = 4'b0;
        m_prev    = 4'b0;
    endtask

    task automatic model_edge(input logic [3:0] irq_in, input logic ie_we,
                              input logic [3:0] wdata, input logic inta, input logic reti);
        logic [3:0] events;
        logic [3:0] act;
        int         first;
        events = irq_in;
`ifdef IRQ_CTRL_EDGE_DETECT_EN
        events = irq_in & ~m_prev;
`endif
        m_prev = irq_in;
        act    = m_pending & m_ie;
        first  = -1;
        for (int i = N - 1; i >= 0; i--) if (act[i]) first = i;
        if (m_mode == 0) begin
            if (first >= 0) begin
                m_mode = 1;
                m_vec  = 2'(first);
            end
        end else if (m_mode == 1) begin
            if (inta) begin
                m_pending[m_vec] = 1'b0;
                m_mode           = 2;
            end else if (!(m_pending[m_vec] && m_ie[m_vec])) begin
                m_mode = 0;
            end
        end else if (reti) begin
            m_mode = 0;
        end
        m_pending = m_pending | events;
        if (ie_we) m_ie = wdata;
    endtask

    function automatic logic [7:0] model_obs();
        return {(m_mode == 1), m_vec, (m_mode == 2), m_pending};
    endfunction

    function automatic logic [7:0] dut_obs();
        return {bus.IRQ, bus.VECTOR, bus.BUSY, bus.PENDING};
    endfunction

    // Drive one cycle of inputs, take the edge, then return inputs to idle.
    task automatic cycle(input logic [3:0] irq_in, input logic ie_we,
                         input logic [3:0] wdata, input logic inta, input logic reti);
        bus.IRQ_IN   = irq_in;
        bus.IE_WE    = ie_we;
        bus.IE_WDATA = wdata;
        bus.INTA     = inta;
        bus.RETI     = reti;
        @(posedge CLK);
        model_edge(irq_in, ie_we, wdata, inta, reti);
        #1;
        bus.IRQ_IN = '0;
        bus.IE_WE  = 1'b0;
        bus.INTA   = 1'b0;
        bus.RETI   = 1'b0;
    endtask

    task automatic idle();
        cycle(4'b0, 1'b0, 4'b0, 1'b0, 1'b0);
    endtask

    logic [7:0] exp;

    task automatic test_reset();
        RST_N = 1'b0;
        bus.IRQ_IN = '0; bus.IE_WE = 1'b0; bus.IE_WDATA = '0; bus.INTA = 1'b0; bus.RETI = 1'b0;
        model_reset();
        #7;
        checks++; exp = 8'b0_00_0_0000;
        if (dut_obs() !== exp) begin errors++; $display("FAIL reset_state: got %b expected %b (irq,vec,busy,pending)", dut_obs(), exp); end
        #1 RST_N = 1'b1;
    endtask

    task automatic test_basic();
        cycle(4'b0, 1'b1, 4'b0001, 1'b0, 1'b0);
        cycle(4'b0001, 1'b0, 4'b0, 1'b0, 1'b0);
        checks++; exp = 8'b0_00_0_0001;
        if (dut_obs() !== exp) begin errors++; $display("FAIL basic_capture: got %b expected %b", dut_obs(), exp); end
        idle();
        checks++; exp = 8'b1_00_0_0001;
        if (dut_obs() !== exp) begin errors++; $display("FAIL basic_request: got %b expected %b", dut_obs(), exp); end
        cycle(4'b0, 1'b0, 4'b0, 1'b1, 1'b0);
        checks++; exp = 8'b0_00_1_0000;
        if (dut_obs() !== exp) begin errors++; $display("FAIL basic_ack: got %b expected %b", dut_obs(), exp); end
        cycle(4'b0, 1'b0, 4'b0, 1'b0, 1'b1);
        checks++; exp = 8'b0_00_0_0000;
        if (dut_obs() !== exp) begin errors++; $display("FAIL basic_reti: got %b expected %b", dut_obs(), exp); end
    endtask

    task automatic test_masked();
        cycle(4'b0, 1'b1, 4'b0000, 1'b0, 1'b0);
        cycle(4'b0100, 1'b0, 4'b0, 1'b0, 1'b0);
        repeat (3) idle();
        checks++; exp = 8'b0_00_0_0100;
        if (dut_obs() !== exp) begin errors++; $display("FAIL masked_hold: got %b expected %b", dut_obs(), exp); end
        cycle(4'b0, 1'b1, 4'b0100, 1'b0, 1'b0);
        checks++; exp = 8'b0_00_0_0100;
        if (dut_obs() !== exp) begin errors++; $display("FAIL unmask_edge: got %b expected %b", dut_obs(), exp); end
        idle();
        checks++; exp = 8'b1_10_0_0100;
        if (dut_obs() !== exp) begin errors++; $display("FAIL unmask_request: got %b expected %b", dut_obs(), exp); end
        cycle(4'b0, 1'b0, 4'b0, 1'b1, 1'b0);
        cycle(4'b0, 1'b0, 4'b0, 1'b0, 1'b1);
        checks++; exp = 8'b0_10_0_0000;
        if (dut_obs() !== exp) begin errors++; $display("FAIL masked_done: got %b expected %b", dut_obs(), exp); end
    endtask

    task automatic test_priority();
        cycle(4'b0, 1'b1, 4'b1111, 1'b0, 1'b0);
        cycle(4'b1010, 1'b0, 4'b0, 1'b0, 1'b0);
        idle();
        checks++; exp = 8'b1_01_0_1010;
        if (dut_obs() !== exp) begin errors++; $display("FAIL prio_first: got %b expected %b", dut_obs(), exp); end
        cycle(4'b0, 1'b0, 4'b0, 1'b1, 1'b0);
        checks++; exp = 8'b0_01_1_1000;
        if (dut_obs() !== exp) begin errors++; $display("FAIL prio_ack: got %b expected %b", dut_obs(), exp); end
        cycle(4'b0, 1'b0, 4'b0, 1'b0, 1'b1);
        idle();
        checks++; exp = 8'b1_11_0_1000;
        if (dut_obs() !== exp) begin errors++; $display("FAIL prio_second: got %b expected %b", dut_obs(), exp); end
        cycle(4'b0, 1'b0, 4'b0, 1'b1, 1'b0);
        cycle(4'b0, 1'b0, 4'b0, 1'b0, 1'b1);
    endtask

    task automatic test_set_wins();
        cycle(4'b0001, 1'b0, 4'b0, 1'b0, 1'b0);
        idle();
        checks++; exp = 8'b1_00_0_0001;
        if (dut_obs() !== exp) begin errors++; $display("FAIL setwins_req: got %b expected %b", dut_obs(), exp); end
        // Same-source event, acknowledge and an enable write all in one cycle.
        cycle(4'b0001, 1'b1, 4'b0101, 1'b1, 1'b0);
        checks++; exp = 8'b0_00_1_0001;
        if (dut_obs() !== exp) begin errors++; $display("FAIL setwins_ack: got %b expected %b", dut_obs(), exp); end
        cycle(4'b0, 1'b0, 4'b0, 1'b0, 1'b1);
        idle();
        checks++; exp = 8'b1_00_0_0001;
        if (dut_obs() !== exp) begin errors++; $display("FAIL setwins_rereq: got %b expected %b", dut_obs(), exp); end
        cycle(4'b0, 1'b0, 4'b0, 1'b1, 1'b0);
        cycle(4'b0, 1'b0, 4'b0, 1'b0, 1'b1);
    endtask

    task automatic test_withdraw();
        cycle(4'b0100, 1'b0, 4'b0, 1'b0, 1'b0);
        idle();
        checks++; exp = 8'b1_10_0_0100;
        if (dut_obs() !== exp) begin errors++; $display("FAIL withdraw_req: got %b expected %b", dut_obs(), exp); end
        cycle(4'b0, 1'b1, 4'b0000, 1'b0, 1'b0);
        idle();
        checks++; exp = 8'b0_10_0_0100;
        if (dut_obs() !== exp) begin errors++; $display("FAIL withdraw_drop: got %b expected %b", dut_obs(), exp); end
        idle();
        checks++;
        if (dut_obs() !== exp) begin errors++; $display("FAIL withdraw_stay: got %b expected %b", dut_obs(), exp); end
    endtask

    task automatic test_async_reset();
        cycle(4'b0, 1'b1, 4'b0100, 1'b0, 1'b0);
        idle();
        cycle(4'b0, 1'b0, 4'b0, 1'b1, 1'b0);
        cycle(4'b0011, 1'b0, 4'b0, 1'b0, 1'b0);
        checks++; exp = 8'b0_10_1_0011;
        if (dut_obs() !== exp) begin errors++; $display("FAIL pre_reset_service: got %b expected %b", dut_obs(), exp); end
        #2 RST_N = 1'b0;
        #1;
        checks++; exp = 8'b0_00_0_0000;
        if (dut_obs() !== exp) begin errors++; $display("FAIL async_reset: got %b expected %b", dut_obs(), exp); end
        model_reset();
        #2 RST_N = 1'b1;
    endtask

    task automatic test_hold();
        int services;
        logic inta;
        logic reti;
        services = 0;
        cycle(4'b0, 1'b1, 4'b0010, 1'b0, 1'b0);
        for (int c = 0; c < 20; c++) begin
            inta = bus.IRQ;
            reti = bus.BUSY;
            if (inta) services++;
            cycle((c < 5) ? 4'b0010 : 4'b0000, 1'b0, 4'b0, inta, reti);
            checks++;
            if (dut_obs() !== model_obs()) begin
                errors++;
                $display("FAIL hold_cycle%0d: got %b expected %b", c, dut_obs(), model_obs());
            end
        end
`ifdef IRQ_CTRL_EDGE_DETECT_EN
        checks++;
        if (services !== 1) begin errors++; $display("FAIL hold_single_service: got %0d services expected 1", services); end
`endif
    endtask

    task automatic test_random();
        logic [3:0] irq_in;
        logic [3:0] wdata;
        logic       ie_we;
        logic       inta;
        logic       reti;
        for (int c = 0; c < 400; c++) begin
            irq_in = 4'($urandom & $urandom & $urandom);
            ie_we  = ($urandom_range(0, 7) == 0);
            wdata  = 4'($urandom);
            inta   = (m_mode == 1) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
            reti   = (m_mode == 2) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            cycle(irq_in, ie_we, wdata, inta, reti);
            checks++;
            if (dut_obs() !== model_obs()) begin
                errors++;
                $display("FAIL random_cycle%0d: got %b expected %b (irq,vec,busy,pending)", c, dut_obs(), model_obs());
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_masked();
        test_priority();
        test_set_wins();
        test_withdraw();
        test_async_reset();
        test_hold();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Interrupt controller that consumes single-cycle interrupt request pulses (IRT) from timer instances and other peripherals.
- Latches each event as pending and masks it with an enable register.
- Arbitrates by fixed priority and presents one request plus a vector to the CPU core.
- Runs an acknowledge / return-from-interrupt handshake with the CPU, so it is the receiving end of the peripherals' IRT interface.

Parameters:
N_SRC, 4, number of interrupt source inputs (2..16)
VEC_W, $clog2(N_SRC), width of VECTOR output (derived, not overridden)

Ports:
CLK  input  1  system clock, all state on rising edge
RST_N  input  1  reset, asynchronous, active-low
IRQ_IN  input  N_SRC  per-source request, one-cycle pulse per event (bit i from peripheral i)
IE_WDATA  input  N_SRC  new interrupt-enable mask
IE_WE  input  1  load IE_WDATA into enable register at next edge
INTA  input  1  CPU acknowledge pulse, valid only while IRQ=1
RETI  input  1  CPU return-from-interrupt pulse, valid only while BUSY=1
IRQ  output  1  interrupt request to CPU (registered)
VECTOR  output  VEC_W  index of the source being requested/serviced (registered)
PENDING  output  N_SRC  raw pending flags, unmasked (status readback)
BUSY  output  1  handler in progress (state SERVICE)

Behaviour:
- Reset (RST_N=0, async):
  - pending=0, ie=0, state=IDLE.
  - IRQ=0, VECTOR=0, BUSY=0, PENDING=0.
- Pending capture:
  - IRQ_IN[i]=1 at edge k sets pending[i] after edge k, regardless of ie[i]. Masked events are recorded, not lost.
  - Multiple pulses on the same source before service collapse into one pending flag.
- Enable register:
  - IE_WE=1 at edge k loads ie after edge k.
  - Arbitration uses the registered ie, so the new mask affects decisions from edge k+1.
- Arbitration: active = pending & ie. Fixed priority, lowest index highest.
- State IDLE:
  - IRQ=0, BUSY=0.
  - If active != 0 at edge: go to REQ, VECTOR <= index of lowest set bit of active, IRQ <= 1.
  - Latency: IRQ_IN pulse at edge k gives IRQ=1 after edge k+1, provided ie is already set.
- State REQ:
  - IRQ=1, VECTOR frozen; a later higher-priority source does not pre-empt.
  - INTA=1: clear pending[VECTOR], go to SERVICE, IRQ <= 0, BUSY <= 1.
  - Otherwise, if ie[VECTOR]=0 or pending[VECTOR]=0 (masked before ack): withdraw, go to IDLE, IRQ <= 0, VECTOR held.
- State SERVICE:
  - IRQ=0, BUSY=1, VECTOR held.
  - New events keep accumulating in pending.
  - RETI=1: go to IDLE, BUSY <= 0. Re-arbitration occurs at the following edge.
- Simultaneous events:
  - IRQ_IN[i] pulse in the same cycle as INTA clearing pending[i]: set wins, pending[i] stays 1.
  - IE_WE in the same cycle as INTA: INTA is honoured, new mask loaded.
- Ignored inputs: INTA outside REQ; RETI outside SERVICE.
- Reset mid-operation: everything returns to reset values immediately. Pending events are discarded.
- Width rules: VECTOR is zero-extended index. Sources with index >= N_SRC do not exist.

Optional Feature:
- Macro: IRQ_CTRL_EDGE_DETECT_EN.
- Defined:
  - Each IRQ_IN bit is treated as a level signal.
  - One register per bit holds the previous value; pending[i] is set on the 0->1 transition only.
  - A level held high sets pending once.
  - The previous-value registers reset to 0.
- Undefined:
  - IRQ_IN is sampled as pulses; every cycle with IRQ_IN[i]=1 sets pending[i].
  - No extra registers.
  - This matches single-cycle IRT sources.

Decomposition:
- Package irq_ctrl_pkg:
  - State enum (IDLE, REQ, SERVICE) as 2-bit typedef.
  - Default N_SRC constant.
  - Function returning the lowest-set-bit index of a vector.
- Sub-module irq_prio_enc: combinational fixed-priority encoder (active -> index, any).
- The edge detector stays inline under the macro.

Test Plan:
- Reset then IE=4'b0001, pulse IRQ_IN=4'b0001 at edge 10 -> PENDING=0001 after edge 10, IRQ=1 and VECTOR=0 after edge 11. INTA -> IRQ=0, BUSY=1, PENDING=0000. RETI -> BUSY=0.
- IE=4'b0000, pulse IRQ_IN[2] -> PENDING=0100, IRQ stays 0. Write IE=4'b0100 -> IRQ=1, VECTOR=2 two edges after the write.
- IE=1111, IRQ_IN=1010 in one cycle -> VECTOR=1. After INTA/RETI -> second request with VECTOR=3.
- In REQ with VECTOR=0, pulse IRQ_IN[0] together with INTA -> PENDING[0]=1 after the edge. After RETI, IRQ reasserts with VECTOR=0.
- In REQ with VECTOR=2, write IE=0000 -> IRQ drops, state IDLE, PENDING[2] still 1.
- Assert RST_N=0 asynchronously mid-SERVICE -> IRQ=0, BUSY=0, PENDING=0 without waiting for CLK. With IRQ_CTRL_EDGE_DETECT_EN, hold IRQ_IN[1]=1 for 5 cycles -> exactly one service.
